// File: rtl/gf2_div_pkg.sv
// Shared types and sizing helpers for the GF(2) polynomial long divider.
// Sizes are functions of N so every instance derives its own widths.
package gf2_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int dw_of(input int n);
    return 2 * n - 1;
  endfunction

  function automatic int qw_of(input int n);
    return n - 1;
  endfunction

  function automatic int iter_count(input int n, input int s);
    return (n - 1 + s - 1) / s;
  endfunction

  localparam int N_DEFAULT = 97;
  localparam int DW        = dw_of(N_DEFAULT);
  localparam int QW        = qw_of(N_DEFAULT);

endpackage

// File: rtl/gf2_div_step.sv
// One combinational long-division step: clears coefficient p of the working
// dividend by subtracting (XOR) the divisor aligned so its leading term lands on p.
module gf2_div_step
  import gf2_div_pkg::*;
#(
  parameter  int N  = 97,
  localparam int DW = 2 * N - 1,
  localparam int PW = $clog2(DW)
) (
  input  logic [DW-1:0] i_w,
  input  logic [N:0]    i_dv,
  input  logic [PW-1:0] i_p,
  input  logic          i_live,
  output logic [DW-1:0] o_w,
  output logic          o_q_bit
);

  logic [DW-1:0] w_dv_wide;
  logic [PW-1:0] w_shift;
  logic          w_hit;

  assign w_dv_wide = DW'(i_dv);
  assign w_shift   = i_p - PW'(N);
  // Positions below N belong to the remainder and are never reduced.
  assign w_hit     = i_live && (i_p >= PW'(N)) && i_w[i_p];
  assign o_w       = w_hit ? (i_w ^ (w_dv_wide << w_shift)) : i_w;
  assign o_q_bit   = w_hit;

endmodule

// File: rtl/gf2_poly_divider.sv
// Sequential GF(2) long divider, S steps per clock, valid/ready on both sides.
// Define GF2_DIV_QUOTIENT_EN to build the quotient register; otherwise q is tied to 0.
module gf2_poly_divider
  import gf2_div_pkg::*;
#(
  parameter int N = 97,
  parameter int S = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-2:0] a,
  input  logic [N:0]     d,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-2:0]   q,
  output logic [N-1:0]   r,
  output logic           err,
  output logic           busy
);

  localparam int DIV_W = dw_of(N);
  localparam int Q_W   = qw_of(N);
  localparam int ITER  = iter_count(N, S);
  localparam int CW    = $clog2(ITER + 1);
  localparam int PW    = $clog2(DIV_W);

  state_t           r_state;
  state_t           w_state_next;
  logic [DIV_W-1:0] r_w;
  logic [N:0]       r_dv;
  logic [CW-1:0]    r_count;
  logic             r_err;
  logic             w_last;

  logic [DIV_W-1:0] w_chain [S+1];
  logic [PW-1:0]    w_pos   [S];
  logic [S-1:0]     w_qbit;

  assign w_last     = (r_count == CW'(ITER - 1));
  assign w_chain[0] = r_w;

  // Step j of cycle c handles dividend position DIV_W-1-(c*S+j); steps past
  // the quotient width are dead and pass the word through.
  for (genvar j = 0; j < S; j++) begin : g_step
    logic [PW-1:0] w_idx;
    logic          w_live;

    assign w_idx    = PW'(r_count) * PW'(S) + PW'(j);
    assign w_live   = (r_state == RUN) && (w_idx < PW'(Q_W));
    assign w_pos[j] = PW'(DIV_W - 1) - w_idx;

    gf2_div_step #(.N(N)) u_step (
      .i_w     (w_chain[j]),
      .i_dv    (r_dv),
      .i_p     (w_pos[j]),
      .i_live  (w_live),
      .o_w     (w_chain[j+1]),
      .o_q_bit (w_qbit[j])
    );
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: defaulting each always_comb output first prevents latch inference.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = d[N] ? RUN : DONE;
      RUN:     if (w_last)   w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      IDLE: in_ready = 1'b1;
      RUN:  busy     = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_w     <= '0;
      r_dv    <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_w     <= d[N] ? a : '0;
          r_dv    <= d[N] ? d : '0;
          r_count <= '0;
          r_err   <= ~d[N];
        end
        RUN: begin
          r_w     <= w_chain[S];
          r_count <= r_count + CW'(1);
        end
        DONE: if (out_ready) begin
          r_w   <= '0;
          r_dv  <= '0;
          r_err <= 1'b0;
        end
        default: r_count <= '0;
      endcase
    end
  end

  assign r   = (r_state == DONE) ? r_w[N-1:0] : '0;
  assign err = (r_state == DONE) & r_err;

`ifdef GF2_DIV_QUOTIENT_EN
  logic [Q_W-1:0] r_qreg;
  logic [Q_W-1:0] w_qreg_next;

  always_comb begin
    w_qreg_next = r_qreg;
    for (int j = 0; j < S; j++) begin
      if (w_qbit[j]) w_qreg_next = w_qreg_next | (Q_W'(1) << (w_pos[j] - PW'(N)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_qreg <= '0;
    end else begin
      case (r_state)
        IDLE:    if (in_valid) r_qreg <= '0;
        RUN:     r_qreg <= w_qreg_next;
        DONE:    if (out_ready) r_qreg <= '0;
        default: r_qreg <= '0;
      endcase
    end
  end

  assign q = (r_state == DONE) ? r_qreg : '0;
`else
  logic w_unused_qbits;
  assign w_unused_qbits = ^w_qbit;
  assign q = '0;
`endif

endmodule

// File: tb/tb_gf2_poly_divider.sv
// Directed and round-trip bench for gf2_poly_divider at N=97 with S=1 and S=5.
// Expected results come from a carry-less multiply model: a = clmul(q0,d) ^ r0.
module tb_gf2_poly_divider;

  localparam int N = 97;
`ifdef GF2_DIV_QUOTIENT_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [192:0] a;
  logic [97:0]  d;
  logic         sel;

  logic        in_ready1, out_valid1, err1, busy1;
  logic [95:0] q1;
  logic [96:0] r1;
  logic        in_ready5, out_valid5, err5, busy5;
  logic [95:0] q5;
  logic [96:0] r5;
  logic        iv1, iv5;

  logic        c_in_ready, c_out_valid, c_err, c_busy;
  logic [95:0] c_q;
  logic [96:0] c_r;

  assign iv1 = in_valid & ~sel;
  assign iv5 = in_valid & sel;
  assign c_in_ready  = sel ? in_ready5  : in_ready1;
  assign c_out_valid = sel ? out_valid5 : out_valid1;
  assign c_err       = sel ? err5       : err1;
  assign c_busy      = sel ? busy5      : busy1;
  assign c_q         = sel ? q5         : q1;
  assign c_r         = sel ? r5         : r1;

  gf2_poly_divider #(.N(N), .S(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(in_ready1), .a(a), .d(d),
    .out_valid(out_valid1), .out_ready(out_ready), .q(q1), .r(r1), .err(err1), .busy(busy1)
  );

  gf2_poly_divider #(.N(N), .S(5)) u_dut5 (
    .clk(clk), .rst(rst), .in_valid(iv5), .in_ready(in_ready5), .a(a), .d(d),
    .out_valid(out_valid5), .out_ready(out_ready), .q(q5), .r(r5), .err(err5), .busy(busy5)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [95:0] exp_q;
  logic [96:0] exp_r;
  logic        exp_err;
  bit          armed = 1'b0;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [192:0] clmul(input logic [95:0] qq, input logic [97:0] dd);
    logic [192:0] acc = '0;
    for (int i = 0; i < 96; i++) begin
      if (qq[i]) acc = acc ^ (193'(dd) << i);
    end
    return acc;
  endfunction

  // Compare process: whenever a result is presented, it must match the model.
  always @(negedge clk) begin
    if (armed && c_out_valid) begin
      check("q", 256'(c_q), 256'(exp_q));
      check("r", 256'(c_r), 256'(exp_r));
      check("err", 256'(c_err), 256'(exp_err));
    end
  end

  task automatic do_op(input logic [192:0] ta, input logic [97:0] td, input logic [95:0] eq,
                       input logic [96:0] er, input logic ee, input int elat, input int hold,
                       input string tag);
    int n;
    n = 0;
    while (!c_in_ready && n < 300) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_in_ready"}, 256'(c_in_ready), 256'(1));
    a        = ta;
    d        = td;
    in_valid = 1'b1;
    exp_q    = QEN ? eq : '0;
    exp_r    = er;
    exp_err  = ee;
    @(posedge clk); #1;
    in_valid = 1'b0;
    armed    = 1'b1;
    n = 0;
    while (!c_out_valid && n < 300) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_latency"}, 256'(n), 256'(elat));
    for (int h = 0; h < hold; h++) begin
      check({tag, "_hold_in_ready"}, 256'(c_in_ready), 256'(0));
      check({tag, "_hold_valid"}, 256'(c_out_valid), 256'(1));
      in_valid = 1'b1;
      a = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      d = {2'b11, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    armed     = 1'b0;
    check({tag, "_post_valid"}, 256'(c_out_valid), 256'(0));
    check({tag, "_post_in_ready"}, 256'(c_in_ready), 256'(1));
    check({tag, "_post_busy"}, 256'(c_busy), 256'(0));
    check({tag, "_post_qr"}, 256'({c_q, c_r}), 256'(0));
  endtask

  task automatic random_rt(input logic [97:0] td, input int elat, input int hold, input string tag);
    logic [95:0] q0;
    logic [96:0] r0;
    q0 = {$urandom, $urandom, $urandom};
    r0 = {1'($urandom_range(0, 1)), $urandom, $urandom, $urandom};
    do_op(clmul(q0, td) ^ 193'(r0), td, q0, r0, 1'b0, elat, hold, tag);
  endtask

  logic [97:0]  d0, d_bad, d_rand;
  logic [192:0] lit_a;
  logic [95:0]  lit_q;
  logic [96:0]  lit_r;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0;
    a = '0; d = '0; exp_q = '0; exp_r = '0; exp_err = 1'b0;
    d0 = '0; d0[97] = 1'b1; d0[6] = 1'b1; d0[0] = 1'b1;
    d_bad = d0; d_bad[97] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", 256'({in_ready1, in_ready5}), 256'(2'b11));
    check("rst_valid", 256'({out_valid1, out_valid5}), 256'(0));
    check("rst_busy_err", 256'({busy1, busy5, err1, err5}), 256'(0));
    check("rst_qr", 256'({q1, r1, q5, r5}), 256'(0));

    // Pin the model: (x^95+x^4)*d0 ^ (x^95+x^10+x^4) == x^192.
    lit_a = '0; lit_a[192] = 1'b1;
    lit_q = '0; lit_q[95] = 1'b1; lit_q[4] = 1'b1;
    lit_r = '0; lit_r[95] = 1'b1; lit_r[10] = 1'b1; lit_r[4] = 1'b1;
    check("model_pin", 256'(clmul(lit_q, d0) ^ 193'(lit_r)), 256'(lit_a));

    do_op('0, d0, '0, '0, 1'b0, 96, 0, "zero");
    do_op(193'(1) << 97, d0, 96'd1, 97'h41, 1'b0, 96, 0, "x97");
    do_op(lit_a, d0, lit_q, lit_r, 1'b0, 96, 0, "x192");
    do_op({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, d_bad,
          '0, '0, 1'b1, 0, 0, "nonmonic");
    do_op(193'(1) << 97, d0, 96'd1, 97'h41, 1'b0, 96, 0, "after_err");
    random_rt(d0, 96, 10, "backpressure");

    // Reset in the middle of RUN discards the operation.
    a = lit_a; d = d0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("mid_run_busy", 256'(busy1), 256'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_run_valid", 256'(out_valid1), 256'(0));
    check("rst_run_ready_busy", 256'({in_ready1, busy1}), 256'(2'b10));
    check("rst_run_qr_err", 256'({q1, r1, err1}), 256'(0));
    do_op(lit_a, d0, lit_q, lit_r, 1'b0, 96, 0, "after_rst");

    for (int i = 0; i < 100; i++) random_rt(d0, 96, 0, "rt1_d0");
    for (int i = 0; i < 80; i++) begin
      d_rand = {1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom};
      random_rt(d_rand, 96, 0, "rt1_rand");
    end

    sel = 1'b1;
    do_op(lit_a, d0, lit_q, lit_r, 1'b0, 20, 0, "s5_x192");
    do_op(193'(1) << 97, d0, 96'd1, 97'h41, 1'b0, 20, 0, "s5_x97");
    do_op('0, d_bad, '0, '0, 1'b1, 0, 0, "s5_nonmonic");
    random_rt(d0, 20, 10, "s5_backpressure");
    for (int i = 0; i < 100; i++) random_rt(d0, 20, 0, "rt5_d0");
    for (int i = 0; i < 100; i++) begin
      d_rand = {1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom};
      random_rt(d_rand, 20, 0, "rt5_rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
